// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: controller sideband, instruction-memory request/response
// and the {pc, inst} handoff to decode.
interface fetch_unit_if;
    logic        booting_i;
    logic        waiting_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    modport master (
        input  booting_i, waiting_i, flush_i, redirect_pc_i, id_ready_i,
               imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o
    );

    modport slave (
        output booting_i, waiting_i, flush_i, redirect_pc_i, id_ready_i,
               imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests, tag FIFO and IFQ.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_IFQ_BYPASS_EN.
module fetch_unit_chk #(
    parameter int OW = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    input logic          rvalid,
    input logic [OW-1:0] outstanding
);
    // A response with nothing in flight is an imem protocol violation; the datapath ignores it
    rvalid_without_request: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rvalid && (outstanding == {OW{1'b0}})));
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          IFQ_DEPTH       = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic          clk_i,
    input logic          rst_i,
    fetch_unit_if.master bus
);
    localparam int PW = (IFQ_DEPTH > 1) ? $clog2(IFQ_DEPTH) : 1;
    localparam int CW = $clog2(IFQ_DEPTH + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OS   = OW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(IFQ_DEPTH);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   tag_r [MAX_OUTSTANDING];
    logic [TW-1:0] tag_rd_r;
    logic [TW-1:0] tag_wr_r;
    logic [OW-1:0] outstanding_r;
    logic [OW-1:0] kill_cnt_r;

    logic [31:0]   ifq_pc_r   [IFQ_DEPTH];
    logic [31:0]   ifq_inst_r [IFQ_DEPTH];
    logic [PW-1:0] ifq_rd_r;
    logic [PW-1:0] ifq_wr_r;
    logic [CW-1:0] ifq_cnt_r;

    logic [OW-1:0] live_s;
    logic [CW:0]   occ_s;
    logic          ifq_empty_s;
    logic          req_s;
    logic          gnt_s;
    logic          rsp_s;
    logic          kill_s;
    logic          accept_s;
    logic          byp_s;
    logic          valid_s;
    logic [31:0]   pc_s;
    logic [31:0]   inst_s;
    logic          pop_s;
    logic          push_s;

    function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] ptr);
        if (ptr == TAG_LAST) begin
            return {TW{1'b0}};
        end else begin
            return ptr + TW'(1'b1);
        end
    endfunction

    // Request gating, response classification and the decode handshake
    always_comb begin
        live_s      = outstanding_r - kill_cnt_r;
        occ_s       = {1'b0, ifq_cnt_r} + (CW + 1)'(live_s);
        ifq_empty_s = (ifq_cnt_r == {CW{1'b0}});
        // Counting live requests against IFQ space guarantees every response has a slot
        req_s       = ~bus.booting_i & ~bus.waiting_i & ~bus.flush_i &
                      (outstanding_r < MAX_OS) & (occ_s < DEPTH_W);
        gnt_s       = req_s & bus.imem_gnt_i;
        rsp_s       = bus.imem_rvalid_i & (outstanding_r != {OW{1'b0}});
        kill_s      = rsp_s & (kill_cnt_r != {OW{1'b0}});
        accept_s    = rsp_s & ~kill_s & ~bus.flush_i;
        byp_s       = 1'b0;
`ifdef FETCH_IFQ_BYPASS_EN
        byp_s       = accept_s & ifq_empty_s;
`else
        byp_s       = 1'b0;
`endif
        if (byp_s) begin
            valid_s = 1'b1;
            pc_s    = tag_r[tag_rd_r];
            inst_s  = bus.imem_rdata_i;
        end else begin
            valid_s = ~bus.flush_i & ~ifq_empty_s;
            pc_s    = ifq_pc_r[ifq_rd_r];
            inst_s  = ifq_inst_r[ifq_rd_r];
        end
        pop_s  = valid_s & bus.id_ready_i & ~byp_s;
        push_s = accept_s & ~(byp_s & bus.id_ready_i);
    end

    assign bus.imem_req_o  = req_s;
    assign bus.imem_addr_o = fetch_pc_r;
    assign bus.if_valid_o  = valid_s;
    assign bus.if_pc_o     = pc_s;
    assign bus.if_inst_o   = inst_s;

    // Fetch PC, in-flight/kill accounting and the tag FIFO of granted PCs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r    <= RESET_PC;
            tag_rd_r      <= {TW{1'b0}};
            tag_wr_r      <= {TW{1'b0}};
            outstanding_r <= {OW{1'b0}};
            kill_cnt_r    <= {OW{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_r[i] <= 32'h0000_0000;
            end
        end else if (bus.flush_i) begin
            // Everything still in flight after this edge belongs to the old path
            fetch_pc_r    <= {bus.redirect_pc_i[31:2], 2'b00};
            tag_rd_r      <= {TW{1'b0}};
            tag_wr_r      <= {TW{1'b0}};
            outstanding_r <= outstanding_r - OW'(rsp_s);
            kill_cnt_r    <= outstanding_r - OW'(rsp_s);
        end else begin
            if (gnt_s) begin
                fetch_pc_r      <= fetch_pc_r + 32'd4;
                tag_r[tag_wr_r] <= fetch_pc_r;
                tag_wr_r        <= tag_next(tag_wr_r);
            end
            if (kill_s) begin
                kill_cnt_r <= kill_cnt_r - OW'(1'b1);
            end
            if (accept_s) begin
                tag_rd_r <= tag_next(tag_rd_r);
            end
            outstanding_r <= outstanding_r + OW'(gnt_s) - OW'(rsp_s);
        end
    end

    // Instruction fetch queue storage and pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifq_rd_r  <= {PW{1'b0}};
            ifq_wr_r  <= {PW{1'b0}};
            ifq_cnt_r <= {CW{1'b0}};
            for (int i = 0; i < IFQ_DEPTH; i++) begin
                ifq_pc_r[i]   <= 32'h0000_0000;
                ifq_inst_r[i] <= 32'h0000_0000;
            end
        end else if (bus.flush_i) begin
            ifq_rd_r  <= {PW{1'b0}};
            ifq_wr_r  <= {PW{1'b0}};
            ifq_cnt_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                ifq_pc_r[ifq_wr_r]   <= tag_r[tag_rd_r];
                ifq_inst_r[ifq_wr_r] <= bus.imem_rdata_i;
                ifq_wr_r             <= ifq_wr_r + PW'(1'b1);
            end
            if (pop_s) begin
                ifq_rd_r <= ifq_rd_r + PW'(1'b1);
            end
            ifq_cnt_r <= ifq_cnt_r + CW'(push_s) - CW'(pop_s);
        end
    end

    fetch_unit_chk #(.OW(OW)) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rvalid      (bus.imem_rvalid_i),
        .outstanding (outstanding_r)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle table for fetch_unit with a queue-based instruction memory model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    logic gnt;
    logic rsp_en;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] pend_q [$];

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .IFQ_DEPTH       (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_gnt_i = gnt;

    // Instruction memory: accepts grants, answers in order one or more cycles later
    always @(posedge clk) begin
        if (rst) begin
            pend_q.delete();
            bus.imem_rvalid_i <= 1'b0;
            bus.imem_rdata_i  <= 32'h0000_0000;
        end else begin
            if (bus.imem_req_o && bus.imem_gnt_i) pend_q.push_back(bus.imem_addr_o);
            if (rsp_en && pend_q.size() > 0) begin
                bus.imem_rvalid_i <= 1'b1;
                bus.imem_rdata_i  <= mem_word(pend_q[0]);
                pend_q.pop_front();
            end else begin
                bus.imem_rvalid_i <= 1'b0;
            end
        end
    end

    typedef struct {
        logic        rst, boot, wt, flush;
        logic [31:0] redir;
        logic        idr, rsp, chk;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input logic r, input logic b, input logic w, input logic f,
                                input logic [31:0] rd, input logic idr, input logic rsp,
                                input logic chk, input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] epc);
        vec_t v;
        v.rst = r; v.boot = b; v.wt = w; v.flush = f; v.redir = rd;
        v.idr = idr; v.rsp = rsp; v.chk = chk;
        v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev; v.exp_pc = epc;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    endtask

    initial begin
        rst = 1'b1; gnt = 1'b1; rsp_en = 1'b1;
        bus.booting_i = 1'b1; bus.waiting_i = 1'b0; bus.flush_i = 1'b0;
        bus.redirect_pc_i = 32'h0000_0000; bus.id_ready_i = 1'b1;

        // Startup, sequential streaming, then decode stall filling the IFQ
        add(0,1,0,0,32'h0,1,1,1, 0,32'h00,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h00,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h04,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h08,1,32'h00);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h0c,1,32'h04);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h10,1,32'h08);
        add(0,0,0,0,32'h0,0,1,1, 1,32'h14,1,32'h0c);
        add(0,0,0,0,32'h0,0,1,1, 1,32'h18,1,32'h0c);
        for (int k = 0; k < 8; k++) add(0,0,0,0,32'h0,0,1,1, 0,32'h1c,1,32'h0c);
        add(0,0,0,0,32'h0,1,1,1, 0,32'h1c,1,32'h0c);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h1c,1,32'h10);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h20,1,32'h14);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h24,1,32'h18);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h28,1,32'h1c);
        add(1,0,0,0,32'h0,1,0,0, 0,32'h00,0,32'h0);
        // Redirect with two requests in flight
        add(0,0,0,0,32'h0,1,0,1, 1,32'h00,0,32'h0);
        add(0,0,0,0,32'h0,1,0,1, 1,32'h04,0,32'h0);
        add(0,0,0,1,32'h203,1,1,1, 0,32'h08,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 0,32'h200,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h200,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h204,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h208,1,32'h200);
        // Redirect coinciding with the only outstanding response
        add(0,0,0,1,32'h1000,1,1,1, 0,32'h20c,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h1000,0,32'h0);
        add(0,0,0,0,32'h0,1,0,1, 1,32'h1004,0,32'h0);
        // WFI with a request in flight
        add(0,0,1,0,32'h0,1,0,1, 0,32'h1008,1,32'h1000);
        add(0,0,1,0,32'h0,1,1,1, 0,32'h1008,0,32'h0);
        add(0,0,1,0,32'h0,1,1,1, 0,32'h1008,0,32'h0);
        add(0,0,1,0,32'h0,1,1,1, 0,32'h1008,1,32'h1004);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h1008,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h100c,0,32'h0);
        // Reset while the IFQ holds three entries
        add(0,0,0,0,32'h0,0,1,1, 1,32'h1010,1,32'h1008);
        add(0,0,0,0,32'h0,0,1,1, 1,32'h1014,1,32'h1008);
        add(1,0,0,0,32'h0,0,1,1, 0,32'h1018,1,32'h1008);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h00,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h04,0,32'h0);
        add(0,0,0,0,32'h0,1,1,1, 1,32'h08,1,32'h00);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_req",   -1, {31'h0, bus.imem_req_o}, 32'h0);
        check("reset_addr",  -1, bus.imem_addr_o, 32'h0);
        check("reset_valid", -1, {31'h0, bus.if_valid_o}, 32'h0);
        check("reset_pc",    -1, bus.if_pc_o, 32'h0);
        check("reset_inst",  -1, bus.if_inst_o, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; bus.booting_i = vecs[i].boot; bus.waiting_i = vecs[i].wt;
            bus.flush_i = vecs[i].flush; bus.redirect_pc_i = vecs[i].redir;
            bus.id_ready_i = vecs[i].idr; rsp_en = vecs[i].rsp;
            #1;
            if (vecs[i].chk) begin
                check("req",   i, {31'h0, bus.imem_req_o}, {31'h0, vecs[i].exp_req});
                check("addr",  i, bus.imem_addr_o, vecs[i].exp_addr);
                check("valid", i, {31'h0, bus.if_valid_o}, {31'h0, vecs[i].exp_valid});
                check("inflight_le_2", i,
                      ((pend_q.size() + int'(bus.imem_rvalid_i)) <= 2) ? 32'h1 : 32'h0, 32'h1);
                if (vecs[i].exp_valid) begin
                    check("pc",   i, bus.if_pc_o, vecs[i].exp_pc);
                    check("inst", i, bus.if_inst_o, mem_word(vecs[i].exp_pc));
                end
            end
        end

        // Ungranted request must hold its address
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            gnt = 1'b0;
            #1;
            check("hold_req",  100 + k, {31'h0, bus.imem_req_o}, 32'h1);
            check("hold_addr", 100 + k, bus.imem_addr_o, 32'h0000_000c);
        end
        @(negedge clk);
        gnt = 1'b1;
        #1;
        check("grant_addr", 103, bus.imem_addr_o, 32'h0000_000c);
        @(negedge clk);
        #1;
        check("next_addr", 104, bus.imem_addr_o, 32'h0000_0010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
